// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Stream rule: a byte moves on a posedge where in_valid and in_ready are both 1; in_ready never depends on in_valid.
interface im_loader_if #(
  parameter int ADDR_W = 7,
  parameter int WORD_W = 15
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [WORD_W-1:0] im_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Loads a framed byte stream (count, lo/hi word bytes, XOR checksum) into instruction memory
// from address 0, holding the CPU until the load completes or aborts.
module im_loader #(
  parameter int ADDR_W = 7,
  parameter int WORD_W = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  im_loader_if.slave    bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [ADDR_W:0] words_loaded,
  output logic [2:0]    state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int WL    = ADDR_W + 1;
  localparam int CW    = (WL > 8) ? WL : 8;
  // Bits of the hi byte that lie above the instruction word and must be zero.
  localparam logic [7:0] HI_MASK = 8'(8'hFF << (WORD_W - 8));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t        state, state_n;
  logic          ready, xfer, accept_start;
  logic          count_bad, hi_bad, last_word, sum_ok;
  logic          enter_done, enter_err;
  logic [CW-1:0] n_ext;
  logic [WL-1:0] count;
  logic [7:0]    lo, checksum;

  assign state_dbg    = state;
  assign bus.in_ready = ready;
  assign n_ext        = CW'(bus.in_data);
  assign count_bad    = (n_ext == '0) || (n_ext > CW'(DEPTH));
  assign hi_bad       = |(bus.in_data & HI_MASK);
  assign last_word    = (words_loaded + WL'(1)) == count;
  assign sum_ok       = (bus.in_data == checksum);
  assign xfer         = bus.in_valid & ready;
  assign accept_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign enter_done   = (state_n == S_DONE) && (state != S_DONE);
  assign enter_err    = (state_n == S_ERR) && (state != S_ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_n = S_COUNT;
      S_COUNT: begin
        ready = 1'b1;
        if (xfer) state_n = count_bad ? S_ERR : S_LO;
      end
      S_LO: begin
        ready = 1'b1;
        if (xfer) state_n = S_HI;
      end
      S_HI: begin
        ready = 1'b1;
        if (xfer) begin
          if (hi_bad)         state_n = S_ERR;
          else if (last_word) state_n = S_CHECK;
          else                state_n = S_LO;
        end
      end
      S_CHECK: begin
        ready = 1'b1;
        if (xfer) state_n = sum_ok ? S_DONE : S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
      lo           <= '0;
      checksum     <= '0;
    end else begin
      bus.im_we <= 1'b0;
      if (accept_start) begin
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        checksum     <= '0;
        cpu_hold     <= 1'b1;
        busy         <= 1'b1;
      end
      if (xfer) begin
        case (state)
          S_COUNT: if (!count_bad) count <= WL'(n_ext);
          S_LO: begin
            lo       <= bus.in_data;
            checksum <= checksum ^ bus.in_data;
          end
          S_HI: begin
            checksum <= checksum ^ bus.in_data;
            // Address and count advance together, so im_addr can never pass count-1.
            if (!hi_bad) begin
              bus.im_we    <= 1'b1;
              bus.im_addr  <= words_loaded[ADDR_W-1:0];
              bus.im_wdata <= {bus.in_data[WORD_W-9:0], lo};
              words_loaded <= words_loaded + WL'(1);
            end
          end
          default: ;
        endcase
      end
      if (enter_done) done  <= 1'b1;
      if (enter_err)  error <= 1'b1;
      if (enter_done || enter_err) begin
        cpu_hold <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule
